store_unit: RTL
===============

Name: store_unit

Overview:
- Store-side counterpart to the MEM-stage load aligner. Takes one store (SB/SH/SW/SWL/SWR) from the EX stage.
- Generates byte strobes and lane-replicated write data, then drives a request/addr_ok/data_ok data-SRAM write handshake.
- Detects misaligned stores (AdES) and reports the faulting address.
- Honours pipeline flush (WS exception / ERET) without corrupting outstanding bus transactions.

Parameters:
- ADDR_W, 32, address width; a 4-byte data bus is fixed.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request from EX.
- st_op  in  3  0=SB 1=SH 2=SW 3=SWL 4=SWR; 5-7 reserved.
- st_addr  in  ADDR_W  effective address.
- st_rt  in  32  rt register value.
- st_ready  out  1  unit can accept a store this cycle.
- flush  in  1  cancel the current store (WS_EX | ERET).
- st_done  out  1  one-cycle pulse: store completed.
- st_ades  out  1  one-cycle pulse: address-error-on-store.
- st_badvaddr  out  ADDR_W  faulting address; valid while st_ades is high.
- data_sram_req  out  1  bus request.
- data_sram_wr  out  1  always 1 while req is high.
- data_sram_size  out  2  0=byte 1=half 2=word.
- data_sram_addr  out  ADDR_W  bus address.
- data_sram_wstrb  out  4  byte enables.
- data_sram_wdata  out  32  write data.
- data_sram_addr_ok  in  1  request accepted.
- data_sram_data_ok  in  1  write response.
- busy  out  1  state != IDLE or a write is outstanding.

Behaviour:
- States: IDLE, EXC, REQ, WAIT, DONE, DISCARD. Reset puts the FSM in IDLE and drives every output 0, except st_ready=1.
- st_ready is 1 only in IDLE. A store is accepted when st_valid & st_ready & !flush. All bus fields are registered at acceptance.
- Alignment check at acceptance, with a = st_addr[1:0]:
  - SH faults when a[0]=1.
  - SW faults when a!=0.
  - A fault goes to EXC: st_ades=1 and st_badvaddr=st_addr for one cycle, no bus request, then IDLE.
- Reserved op: no request; go to DONE, pulse st_done, then IDLE.
- Lane rules, with a = addr[1:0] and sh = 8a:
  - SB: size 0, addr unchanged, wstrb = 0001<<a, wdata = {4{rt[7:0]}}.
  - SH: size 1, addr unchanged, wstrb = a[1] ? 1100 : 0011, wdata = {2{rt[15:0]}}.
  - SW: size 2, addr unchanged, wstrb = 1111, wdata = rt.
  - SWL: size 2, addr = {addr[31:2],00}, wstrb = a=0:0001, 1:0011, 2:0111, 3:1111; wdata = rt >> (24-sh).
  - SWR: size 2, addr = {addr[31:2],00}, wstrb = a=0:1111, 1:1110, 2:1100, 3:1000; wdata = rt << sh.
- REQ: data_sram_req=1 and all bus fields held stable until data_sram_addr_ok is sampled high; then go to WAIT and drop req the next cycle.
- WAIT: on data_ok go to DONE. DONE pulses st_done=1 for one cycle, then IDLE.
- Nominal latency: accept at T, req at T+1, addr_ok at T+1, data_ok at T+2, st_done at T+3.
- data_ok sampled in IDLE/REQ/EXC with nothing outstanding is a protocol violation and is ignored.
- At most one outstanding write.
- flush handling:
  - In IDLE or EXC: nothing accepted, st_ades suppressed, back to IDLE.
  - In REQ without addr_ok that cycle: req dropped next cycle, IDLE.
  - In REQ with addr_ok the same cycle, or in WAIT: go to DISCARD. DISCARD waits for data_ok with st_ready=0, then IDLE with no st_done.
  - In DONE: st_done is suppressed.
- Reset mid-transaction: immediate return to IDLE. The bus is owned by the same reset domain.

Optional Feature:
- Macro STORE_POST_EN.
- Defined (posted writes):
  - st_done pulses the cycle after addr_ok. The FSM returns to IDLE and a 1-bit outstanding flag is set.
  - A new store may be accepted and its alignment checked, but its REQ is withheld until data_ok clears the flag.
  - flush never cancels a write that has already been posted.
- Undefined: behaviour as above, with completion signalled at data_ok.

Test Plan:
- SB, addr 0x1003, rt 0x123456AB, addr_ok and data_ok immediate -> req at T+1 with size 0, wstrb 1000, wdata 0xABABABAB; st_done at T+3.
- SWL addr 0x2001 rt 0xAABBCCDD -> addr 0x2000, wstrb 0011, wdata 0x0000AABB. SWR addr 0x2002 -> wstrb 1100, wdata 0xCCDD0000.
- SW addr 0x3002 -> st_ades pulse, st_badvaddr 0x3002, no req, st_ready back high two cycles after acceptance. SH addr 0x3001 -> same fault behaviour.
- SH addr 0x4002 with addr_ok held low 5 cycles -> req, addr, wstrb 1100 and wdata held stable for all 5 cycles; single st_done after data_ok.
- flush in WAIT, data_ok 3 cycles later -> DISCARD, st_ready=0 until data_ok, no st_done. flush in REQ with addr_ok low -> req drops next cycle, no st_done.
- With STORE_POST_EN: two back-to-back SWs -> st_done after the first addr_ok; second req not raised until first data_ok; resetn low mid-WAIT -> all outputs 0, st_ready=1.

Source files
------------

// File: rtl/store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_unit: SB/SH/SW/SWL/SWR lane alignment + data-SRAM write handshake. |
// | Optional macro STORE_POST_EN: posted writes (done at addr_ok).  Rev 1.0  |
// +--------------------------------------------------------------------------+
module store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              st_valid,
  input  logic [2:0]        st_op,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_rt,
  output logic              st_ready,
  input  logic              flush,
  output logic              st_done,
  output logic              st_ades,
  output logic [ADDR_W-1:0] st_badvaddr,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [3:0]        data_sram_wstrb,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  output logic              busy
);

`ifdef STORE_POST_EN
  localparam bit POST_EN = 1'b1;
`else
  localparam bit POST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXC     = 3'd1,
    S_REQ     = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4,
    S_DISCARD = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              out_q, out_d;

  logic [1:0]        lane_a;
  logic [4:0]        lane_sh;
  logic [ADDR_W-1:0] ln_addr;
  logic [1:0]        ln_size;
  logic [3:0]        ln_wstrb;
  logic [31:0]       ln_wdata;
  logic              ln_fault;
  logic              ln_rsvd;
  logic              accept;
  logic              req;
  logic              req_acc;

  // Lane placement of the incoming store, evaluated on the EX-side inputs.
  always_comb begin
    lane_a   = st_addr[1:0];
    lane_sh  = {lane_a, 3'b000};
    ln_addr  = st_addr;
    ln_size  = 2'd2;
    ln_wstrb = 4'b0000;
    ln_wdata = 32'h0;
    ln_fault = 1'b0;
    ln_rsvd  = 1'b0;
    case (st_op)
      3'd0: begin
        ln_size  = 2'd0;
        ln_wstrb = 4'b0001 << lane_a;
        ln_wdata = {4{st_rt[7:0]}};
      end
      3'd1: begin
        ln_size  = 2'd1;
        ln_wstrb = lane_a[1] ? 4'b1100 : 4'b0011;
        ln_wdata = {2{st_rt[15:0]}};
        ln_fault = lane_a[0];
      end
      3'd2: begin
        ln_wstrb = 4'b1111;
        ln_wdata = st_rt;
        ln_fault = (lane_a != 2'd0);
      end
      3'd3: begin
        ln_addr  = {st_addr[ADDR_W-1:2], 2'b00};
        ln_wdata = st_rt >> (5'd24 - lane_sh);
        case (lane_a)
          2'd0:    ln_wstrb = 4'b0001;
          2'd1:    ln_wstrb = 4'b0011;
          2'd2:    ln_wstrb = 4'b0111;
          default: ln_wstrb = 4'b1111;
        endcase
      end
      3'd4: begin
        ln_addr  = {st_addr[ADDR_W-1:2], 2'b00};
        ln_wdata = st_rt << lane_sh;
        case (lane_a)
          2'd0:    ln_wstrb = 4'b1111;
          2'd1:    ln_wstrb = 4'b1110;
          2'd2:    ln_wstrb = 4'b1100;
          default: ln_wstrb = 4'b1000;
        endcase
      end
      default: ln_rsvd = 1'b1;
    endcase
  end

  assign st_ready = (state_q == S_IDLE);
  assign accept   = st_valid & st_ready & ~flush;
  // With posting, a queued request waits until the previous write responds.
  assign req      = (state_q == S_REQ) & ~(POST_EN & out_q);
  assign req_acc  = req & data_sram_addr_ok;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    out_d   = out_q;
    if (out_q && data_sram_data_ok) out_d = 1'b0;
    if (req_acc)                    out_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = ln_addr;
          size_d  = ln_size;
          wstrb_d = ln_wstrb;
          wdata_d = ln_wdata;
          if (ln_fault)     state_d = S_EXC;
          else if (ln_rsvd) state_d = S_DONE;
          else              state_d = S_REQ;
        end
      end
      S_EXC:  state_d = S_IDLE;
      S_REQ: begin
        if (req_acc) begin
          if (POST_EN) state_d = flush ? S_IDLE : S_DONE;
          else         state_d = flush ? S_DISCARD : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_sram_data_ok) state_d = flush ? S_IDLE : S_DONE;
        else if (flush)        state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (data_sram_data_ok) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= 2'd0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      out_q   <= out_d;
    end
  end

  assign st_done         = (state_q == S_DONE) & ~flush;
  assign st_ades         = (state_q == S_EXC) & ~flush;
  // Faulting ops (SH/SW) keep the address unmodified, so addr_q is the EA.
  assign st_badvaddr     = st_ades ? addr_q : '0;
  assign data_sram_req   = req;
  assign data_sram_wr    = req;
  assign data_sram_size  = req ? size_q : 2'd0;
  assign data_sram_addr  = req ? addr_q : '0;
  assign data_sram_wstrb = req ? wstrb_q : 4'b0000;
  assign data_sram_wdata = req ? wdata_q : 32'h0;
  assign busy            = (state_q != S_IDLE) | out_q;

endmodule
`default_nettype wire
